load_store: RTL and testbench
=============================

Name: load_store

Overview:
- Memory/writeback stage placed directly downstream of execute.
- Consumes the execute result (ALU value or effective address), rs2 store data, rd and rd_write.
- Performs loads and stores on a data RAM port using the same req/gnt/rvalid handshake as the instruction RAM.
- Returns the registered writeback triple (rd, rd_write, value) to decode's register file.

Parameters:
- TIMEOUT_CYCLES, 16, bus wait limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
- req  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- valid_in  input  1  execute output valid
- alu_opcode_in  input  7  instruction opcode
- funct3_in  input  3  access size/sign
- result_in  input  32  ALU result / effective address
- rs2_value_in  input  32  store data
- rd_in  input  5  destination register
- rd_write_in  input  1  destination write enable
- data_req_out  output  1  bus request
- data_addr_out  output  32  word address, bits [1:0] = 0
- data_we_out  output  1  1 = store
- data_be_out  output  4  byte enables
- data_wdata_out  output  32  store data, lane-aligned
- data_gnt_in  input  1  request accepted
- data_rvalid_in  input  1  read data valid
- data_rdata_in  input  32  read data
- stall_out  output  1  upstream must hold its instruction
- rd_out  output  5  writeback register
- rd_write_out  output  1  writeback enable, one-cycle pulse
- rd_value_out  output  32  writeback value
- misaligned_out  output  1  misaligned access pulse
- bus_err_out  output  1  timeout pulse (LSU_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset: state IDLE; all outputs 0; internal captured registers 0. The reset is asynchronous and drops data_req_out immediately, including mid-access. An rvalid arriving after reset is ignored.
- Opcode decode: 0000011 = load, 0100011 = store, anything else = pass-through.
- Inputs are sampled only at a rising edge in IDLE with valid_in=1.
- Pass-through: at the next edge, rd_out=rd_in, rd_value_out=result_in, rd_write_out=rd_write_in.
  - Latency 1; the state machine stays in IDLE.
- x0 suppression: rd_write_out is forced 0 whenever rd==0.
- valid_in=0 in IDLE: rd_write_out=0 at the next edge.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE with a legal, aligned memory op:
  - Capture address, data, rd, funct3 and the load/store flag.
  - Go to REQ; data_req_out=1 is registered.
- REQ:
  - Hold data_req_out and all data_* outputs stable until data_gnt_in=1.
  - On gnt with a store: go to DONE.
  - On gnt with a load: data_req_out=0, go to WAIT.
- WAIT: on data_rvalid_in=1, extract/extend the load data into rd_value_out, go to DONE.
- DONE:
  - Load: rd_write_out pulses (subject to rd!=0).
  - Store: rd_write_out=0.
  - Return to IDLE.
- stall_out is registered and is 1 exactly while state is REQ, WAIT or DONE. An instruction presented while stall_out=1 is not sampled; upstream holds it.
- Addressing: data_addr_out={addr[31:2],2'b00}.
- Stores:
  - SB (000): be=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH (001): be=0011<<(2*addr[1]), wdata={2{rs2[15:0]}}.
  - SW (010): be=1111, wdata=rs2.
  - data_we_out=1.
- Loads: data_we_out=0, be=1111. The result is selected by addr[1:0] from data_rdata_in:
  - LB (000): sign-extend the selected byte.
  - LBU (100): zero-extend the selected byte.
  - LH (001): sign-extend the selected halfword.
  - LHU (101): zero-extend the selected halfword.
  - LW (010): full 32 bits.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No bus access, no writeback, state stays IDLE.
  - misaligned_out pulses for 1 cycle.
- Illegal funct3: load 011/110/111 or store >=011. Treated as a NOP: no access, no writeback, no flag.
- A gnt and rvalid in the same cycle for a load are both honoured: REQ goes directly to DONE with the data captured.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: a counter clears on entry to REQ/WAIT and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES without gnt (REQ) or rvalid (WAIT), the access aborts: data_req_out=0, state goes to IDLE.
  - bus_err_out pulses for 1 cycle; no writeback.
- Undefined: no counter; bus_err_out is tied 0; the block waits indefinitely.

Test Plan:
- Pass-through: opcode 0010011, result 0x0000002A, rd=5, rd_write=1 -> next edge rd_out=5, rd_value_out=0x2A, rd_write_out=1 for one cycle; stall_out stays 0.
- LB: addr 0x103, rdata 0x80FF1234, gnt and rvalid 1 cycle each -> data_addr_out=0x100, rd_value_out=0xFFFFFF80, stall_out high for 3 cycles.
- SH: addr 0x202, rs2=0x1234ABCD, gnt delayed 3 cycles -> data_req_out held 4 cycles, be=1100, wdata=0xABCDABCD, we=1; no writeback.
- LW at addr 0x301 -> misaligned_out pulse, data_req_out never asserted; rd=0 load at an aligned address -> rd_write_out stays 0.
- Reset (low) asserted while in WAIT -> data_req_out and stall_out drop 0 immediately; a late rvalid produces no writeback.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt never returned -> bus_err_out pulses after 4 cycles in REQ; FSM returns to IDLE and accepts the next instruction.

Source files
------------

// File: rtl/load_store.sv
// load_store: memory / writeback stage sitting directly after execute.
//
// Takes the execute result (ALU value or effective address), the rs2 store
// data and the destination register, performs loads and stores over a data
// RAM port with a req/gnt/rvalid handshake, and returns a registered
// writeback triple (rd, rd_write, value) to the register file in decode.
//
// Optional build feature: define LSU_TIMEOUT_EN to abort a bus access that
// waits TIMEOUT_CYCLES cycles for gnt or rvalid (bus_err_out then pulses).
// Without it bus_err_out is tied 0 and the stage waits indefinitely.
//
// Ports:
//   req             clock, rising edge
//   reset           asynchronous active-low reset
//   valid_in        execute output valid
//   alu_opcode_in   instruction opcode (load / store / anything else)
//   funct3_in       access size and sign
//   result_in       ALU result or effective address
//   rs2_value_in    store data
//   rd_in           destination register
//   rd_write_in     destination write enable (pass-through instructions)
//   data_req_out    bus request, held until data_gnt_in
//   data_addr_out   word address, bits [1:0] always 0
//   data_we_out     1 = store
//   data_be_out     byte enables
//   data_wdata_out  lane-aligned store data
//   data_gnt_in     request accepted
//   data_rvalid_in  read data valid
//   data_rdata_in   read data
//   stall_out       upstream must hold its instruction
//   rd_out          writeback register
//   rd_write_out    writeback enable, one-cycle pulse, never for x0
//   rd_value_out    writeback value
//   misaligned_out  one-cycle pulse on a misaligned access
//   bus_err_out     one-cycle pulse on a bus timeout

module load_store #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        req,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [6:0]  alu_opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  output logic        data_req_out,
  output logic [31:0] data_addr_out,
  output logic        data_we_out,
  output logic [3:0]  data_be_out,
  output logic [31:0] data_wdata_out,
  input  logic        data_gnt_in,
  input  logic        data_rvalid_in,
  input  logic [31:0] data_rdata_in,
  output logic        stall_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_load_q, is_load_d;
  logic        stall_q, stall_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic        rd_write_q, rd_write_d;
  logic [31:0] rd_value_q, rd_value_d;
  logic        misaligned_q, misaligned_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
`endif

  // Decode of the incoming instruction, only meaningful in IDLE.
  logic        load_op, store_op, f3_legal, misaligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_value;

  // Sign/zero extension of the addressed byte or halfword of a load.
  function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                               input logic [1:0]  a,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  extract_load = {{24{b[7]}}, b};
      3'b100:  extract_load = {24'b0, b};
      3'b001:  extract_load = {{16{h[15]}}, h};
      3'b101:  extract_load = {16'b0, h};
      default: extract_load = d;
    endcase
  endfunction

  always_comb begin
    load_op  = (alu_opcode_in == OP_LOAD);
    store_op = (alu_opcode_in == OP_STORE);
    // Loads allow 000/001/010/100/101, stores only 000..010.
    if (load_op) f3_legal = (funct3_in != 3'b011) && (funct3_in[2:1] != 2'b11);
    else         f3_legal = (funct3_in <= 3'b010);
    misaligned = ((funct3_in[1:0] == 2'b01) && result_in[0]) ||
                 ((funct3_in[1:0] == 2'b10) && (result_in[1:0] != 2'b00));
    // Store data is replicated so every lane carries it; be picks the lane.
    case (funct3_in[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << result_in[1:0];
        lane_wdata = {4{rs2_value_in[7:0]}};
      end
      2'b01: begin
        lane_be    = result_in[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{rs2_value_in[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = rs2_value_in;
      end
    endcase
    load_value = extract_load(funct3_q, addr_q[1:0], data_rdata_in);
  end

  // Next-state logic. Writeback and flag pulses default to 0 each cycle;
  // everything else holds unless a state below updates it.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    req_d        = req_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    is_load_d    = is_load_q;
    rd_out_d     = rd_out_q;
    rd_value_d   = rd_value_q;
    rd_write_d   = 1'b0;
    misaligned_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
    bus_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (load_op || store_op) begin
            // Illegal funct3 falls through as a silent NOP.
            if (f3_legal) begin
              if (misaligned) begin
                misaligned_d = 1'b1;
              end else begin
                addr_d    = result_in;
                funct3_d  = funct3_in;
                rd_d      = rd_in;
                is_load_d = load_op;
                we_d      = store_op;
                be_d      = store_op ? lane_be : 4'b1111;
                wdata_d   = store_op ? lane_wdata : 32'b0;
                req_d     = 1'b1;
                state_d   = REQ;
`ifdef LSU_TIMEOUT_EN
                cnt_d     = '0;
`endif
              end
            end
          end else begin
            rd_out_d   = rd_in;
            rd_value_d = result_in;
            rd_write_d = rd_write_in && (rd_in != 5'd0);
          end
        end
      end
      REQ: begin
        if (data_gnt_in) begin
          req_d = 1'b0;
          if (!is_load_q) begin
            state_d = DONE;
          end else if (data_rvalid_in) begin
            // gnt and rvalid together: skip WAIT entirely.
            rd_out_d   = rd_q;
            rd_value_d = load_value;
            rd_write_d = (rd_q != 5'd0);
            state_d    = DONE;
          end else begin
            state_d = WAIT;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WAIT: begin
        if (data_rvalid_in) begin
          rd_out_d   = rd_q;
          rd_value_d = load_value;
          rd_write_d = (rd_q != 5'd0);
          state_d    = DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    // Registered so that stall is high exactly while the FSM is busy.
    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      req_q        <= 1'b0;
      funct3_q     <= '0;
      rd_q         <= '0;
      is_load_q    <= 1'b0;
      stall_q      <= 1'b0;
      rd_out_q     <= '0;
      rd_write_q   <= 1'b0;
      rd_value_q   <= '0;
      misaligned_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      we_q         <= we_d;
      req_q        <= req_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      is_load_q    <= is_load_d;
      stall_q      <= stall_d;
      rd_out_q     <= rd_out_d;
      rd_write_q   <= rd_write_d;
      rd_value_q   <= rd_value_d;
      misaligned_q <= misaligned_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= cnt_d;
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  assign data_req_out   = req_q;
  assign data_addr_out  = {addr_q[31:2], 2'b00};
  assign data_we_out    = we_q;
  assign data_be_out    = be_q;
  assign data_wdata_out = wdata_q;
  assign stall_out      = stall_q;
  assign rd_out         = rd_out_q;
  assign rd_write_out   = rd_write_q;
  assign rd_value_out   = rd_value_q;
  assign misaligned_out = misaligned_q;
`ifdef LSU_TIMEOUT_EN
  assign bus_err_out    = bus_err_q;
`else
  assign bus_err_out    = 1'b0;
`endif

endmodule

// File: tb/tb_load_store.sv
// Testbench for load_store: a table of directed instruction vectors, each
// with its own bus response timing and hand-computed expected outputs,
// followed by hand-written sequences for reset mid-access, holding an
// instruction across a stall, and the bus timeout (or indefinite wait).

module tb_load_store;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [31:0] JUNK = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [6:0]  alu_opcode_in = '0;
  logic [2:0]  funct3_in = '0;
  logic [31:0] result_in = '0;
  logic [31:0] rs2_value_in = '0;
  logic [4:0]  rd_in = '0;
  logic        rd_write_in = 1'b0;
  logic        data_req_out;
  logic [31:0] data_addr_out;
  logic        data_we_out;
  logic [3:0]  data_be_out;
  logic [31:0] data_wdata_out;
  logic        data_gnt_in = 1'b0;
  logic        data_rvalid_in = 1'b0;
  logic [31:0] data_rdata_in = JUNK;
  logic        stall_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] rd_value_out;
  logic        misaligned_out;
  logic        bus_err_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store #(.TIMEOUT_CYCLES(4)) dut (
    .req            (clk),
    .reset          (rst_n),
    .valid_in       (valid_in),
    .alu_opcode_in  (alu_opcode_in),
    .funct3_in      (funct3_in),
    .result_in      (result_in),
    .rs2_value_in   (rs2_value_in),
    .rd_in          (rd_in),
    .rd_write_in    (rd_write_in),
    .data_req_out   (data_req_out),
    .data_addr_out  (data_addr_out),
    .data_we_out    (data_we_out),
    .data_be_out    (data_be_out),
    .data_wdata_out (data_wdata_out),
    .data_gnt_in    (data_gnt_in),
    .data_rvalid_in (data_rvalid_in),
    .data_rdata_in  (data_rdata_in),
    .stall_out      (stall_out),
    .rd_out         (rd_out),
    .rd_write_out   (rd_write_out),
    .rd_value_out   (rd_value_out),
    .misaligned_out (misaligned_out),
    .bus_err_out    (bus_err_out)
  );

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] result;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rdw;
    int          gdly;
    int          rdly;
    logic        same;
    logic [31:0] rdata;
    logic        exp_bus;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_wr;
    logic [31:0] exp_val;
    logic        exp_mis;
    int          exp_stall;
  } vec_t;

  vec_t vecs[$];

  // One comparison; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one instruction for one rising edge, then withdraws it.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    valid_in      = 1'b1;
    alu_opcode_in = v.op;
    funct3_in     = v.f3;
    result_in     = v.result;
    rs2_value_in  = v.rs2;
    rd_in         = v.rd;
    rd_write_in   = v.rdw;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Runs one vector including its bus responses and checks the results.
  task automatic runVector(input vec_t v);
    int  stalls;
    int  reqs;
    bit  is_load;
    is_load = (v.op == LD);
    stalls  = 0;
    reqs    = 0;
    applyStimulus(v);
    checkOutput({v.name, "_req"}, 32'(data_req_out), 32'(v.exp_bus));
    checkOutput({v.name, "_mis"}, 32'(misaligned_out), 32'(v.exp_mis));
    stalls += int'(stall_out);
    if (v.exp_bus) begin
      checkOutput({v.name, "_addr"}, data_addr_out, v.exp_addr);
      checkOutput({v.name, "_we"}, 32'(data_we_out), 32'(v.exp_we));
      checkOutput({v.name, "_be"}, 32'(data_be_out), 32'(v.exp_be));
      if (v.exp_we) checkOutput({v.name, "_wdata"}, data_wdata_out, v.exp_wdata);
      reqs += int'(data_req_out);
      for (int d = 0; d < v.gdly; d++) begin
        @(negedge clk);
        stalls += int'(stall_out);
        reqs   += int'(data_req_out);
      end
      data_gnt_in = 1'b1;
      if (v.same) begin
        data_rvalid_in = 1'b1;
        data_rdata_in  = v.rdata;
      end
      @(negedge clk);
      data_gnt_in    = 1'b0;
      data_rvalid_in = 1'b0;
      data_rdata_in  = JUNK;
      stalls += int'(stall_out);
      reqs   += int'(data_req_out);
      if (is_load && !v.same) begin
        for (int d = 0; d < v.rdly; d++) begin
          @(negedge clk);
          stalls += int'(stall_out);
        end
        data_rvalid_in = 1'b1;
        data_rdata_in  = v.rdata;
        @(negedge clk);
        data_rvalid_in = 1'b0;
        data_rdata_in  = JUNK;
        stalls += int'(stall_out);
      end
      checkOutput({v.name, "_reqcycles"}, 32'(reqs), 32'(v.gdly + 1));
    end
    checkOutput({v.name, "_wr"}, 32'(rd_write_out), 32'(v.exp_wr));
    if (v.exp_wr) checkOutput({v.name, "_rd"}, 32'(rd_out), 32'(v.rd));
    if (v.exp_wr || (v.exp_bus && is_load))
      checkOutput({v.name, "_val"}, rd_value_out, v.exp_val);
    @(negedge clk);
    stalls += int'(stall_out);
    checkOutput({v.name, "_wr_pulse"}, 32'(rd_write_out), 32'h0);
    checkOutput({v.name, "_mis_pulse"}, 32'(misaligned_out), 32'h0);
    checkOutput({v.name, "_stalls"}, 32'(stalls), 32'(v.exp_stall));
  endtask

  initial begin
    int   reqs;
    int   errs;
    int   err_at;
    vec_t v;

    //           name        op   f3    result        rs2           rd     rdw   g r same  rdata          bus   addr          we    be       wdata          wr    val            mis  stall
    vecs.push_back('{"pass",    OPI, 3'd0, 32'h0000002A, 32'h0,        5'd5,  1'b1, 0,0,1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 4'h0,    32'h0,         1'b1, 32'h0000002A, 1'b0, 0});
    vecs.push_back('{"pass_x0", 7'b0110011, 3'd0, 32'h99, 32'h0,       5'd0,  1'b1, 0,0,1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 4'h0,    32'h0,         1'b0, 32'h0,        1'b0, 0});
    vecs.push_back('{"pass_nowr",OPI,3'd0, 32'h77,       32'h0,        5'd7,  1'b0, 0,0,1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 4'h0,    32'h0,         1'b0, 32'h0,        1'b0, 0});
    vecs.push_back('{"lb",      LD,  3'd0, 32'h00000103, 32'h0,        5'd10, 1'b1, 0,0,1'b0, 32'h80FF1234,  1'b1, 32'h00000100, 1'b0, 4'hF,    32'h0,         1'b1, 32'hFFFFFF80, 1'b0, 3});
    vecs.push_back('{"lbu",     LD,  3'd4, 32'h00000102, 32'h0,        5'd11, 1'b1, 0,0,1'b0, 32'h80FF1234,  1'b1, 32'h00000100, 1'b0, 4'hF,    32'h0,         1'b1, 32'h000000FF, 1'b0, 3});
    vecs.push_back('{"lb0",     LD,  3'd0, 32'h00000100, 32'h0,        5'd15, 1'b1, 0,0,1'b0, 32'h0000007F,  1'b1, 32'h00000100, 1'b0, 4'hF,    32'h0,         1'b1, 32'h0000007F, 1'b0, 3});
    vecs.push_back('{"lh",      LD,  3'd1, 32'h00000402, 32'h0,        5'd12, 1'b1, 1,2,1'b0, 32'h80FF1234,  1'b1, 32'h00000400, 1'b0, 4'hF,    32'h0,         1'b1, 32'hFFFF80FF, 1'b0, 6});
    vecs.push_back('{"lhu",     LD,  3'd5, 32'h00000400, 32'h0,        5'd13, 1'b1, 2,1,1'b0, 32'h8000F00D,  1'b1, 32'h00000400, 1'b0, 4'hF,    32'h0,         1'b1, 32'h0000F00D, 1'b0, 6});
    vecs.push_back('{"lw_same", LD,  3'd2, 32'h00000500, 32'h0,        5'd14, 1'b1, 0,0,1'b1, 32'hDEADBEEF,  1'b1, 32'h00000500, 1'b0, 4'hF,    32'h0,         1'b1, 32'hDEADBEEF, 1'b0, 2});
    vecs.push_back('{"sb",      ST,  3'd0, 32'h00000601, 32'h123456A5, 5'd3,  1'b1, 0,0,1'b0, 32'h0,         1'b1, 32'h00000600, 1'b1, 4'b0010, 32'hA5A5A5A5,  1'b0, 32'h0,        1'b0, 2});
    vecs.push_back('{"sh",      ST,  3'd1, 32'h00000202, 32'h1234ABCD, 5'd3,  1'b1, 3,0,1'b0, 32'h0,         1'b1, 32'h00000200, 1'b1, 4'b1100, 32'hABCDABCD,  1'b0, 32'h0,        1'b0, 5});
    vecs.push_back('{"sw",      ST,  3'd2, 32'h00000700, 32'hCAFEF00D, 5'd3,  1'b1, 1,0,1'b0, 32'h0,         1'b1, 32'h00000700, 1'b1, 4'hF,    32'hCAFEF00D,  1'b0, 32'h0,        1'b0, 3});
    vecs.push_back('{"lw_mis",  LD,  3'd2, 32'h00000301, 32'h0,        5'd4,  1'b1, 0,0,1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 4'h0,    32'h0,         1'b0, 32'h0,        1'b1, 0});
    vecs.push_back('{"lh_mis",  LD,  3'd1, 32'h00000303, 32'h0,        5'd4,  1'b1, 0,0,1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 4'h0,    32'h0,         1'b0, 32'h0,        1'b1, 0});
    vecs.push_back('{"sh_mis",  ST,  3'd1, 32'h00000205, 32'h0000FFFF, 5'd4,  1'b1, 0,0,1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 4'h0,    32'h0,         1'b0, 32'h0,        1'b1, 0});
    vecs.push_back('{"sw_mis",  ST,  3'd2, 32'h00000702, 32'h1,        5'd4,  1'b1, 0,0,1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 4'h0,    32'h0,         1'b0, 32'h0,        1'b1, 0});
    vecs.push_back('{"lw_x0",   LD,  3'd2, 32'h00000800, 32'h0,        5'd0,  1'b1, 0,0,1'b0, 32'h11111111,  1'b1, 32'h00000800, 1'b0, 4'hF,    32'h0,         1'b0, 32'h11111111, 1'b0, 3});
    vecs.push_back('{"ld_ill",  LD,  3'd3, 32'h00000900, 32'h0,        5'd8,  1'b1, 0,0,1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 4'h0,    32'h0,         1'b0, 32'h0,        1'b0, 0});
    vecs.push_back('{"st_ill",  ST,  3'd4, 32'h00000904, 32'h1,        5'd8,  1'b1, 0,0,1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 4'h0,    32'h0,         1'b0, 32'h0,        1'b0, 0});

    // Reset state.
    #3;
    checkOutput("rst_req", 32'(data_req_out), 32'h0);
    checkOutput("rst_stall", 32'(stall_out), 32'h0);
    checkOutput("rst_wr", 32'(rd_write_out), 32'h0);
    checkOutput("rst_val", rd_value_out, 32'h0);
    checkOutput("rst_be", 32'(data_be_out), 32'h0);
    checkOutput("rst_mis", 32'(misaligned_out), 32'h0);
    checkOutput("rst_err", 32'(bus_err_out), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) runVector(vecs[i]);

    // Reset during REQ drops the request without waiting for a clock edge.
    v = vecs[0];
    v.op = LD; v.f3 = 3'd2; v.result = 32'h120; v.rd = 5'd6;
    applyStimulus(v);
    checkOutput("rstreq_pre_req", 32'(data_req_out), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstreq_req", 32'(data_req_out), 32'h0);
    checkOutput("rstreq_stall", 32'(stall_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WAIT; the late rvalid must be ignored.
    applyStimulus(v);
    data_gnt_in = 1'b1;
    @(negedge clk);
    data_gnt_in = 1'b0;
    checkOutput("rstwait_in_wait", 32'(stall_out), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstwait_stall", 32'(stall_out), 32'h0);
    checkOutput("rstwait_req", 32'(data_req_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    data_rvalid_in = 1'b1;
    data_rdata_in  = 32'h12345678;
    @(negedge clk);
    data_rvalid_in = 1'b0;
    data_rdata_in  = JUNK;
    checkOutput("late_rvalid_wr", 32'(rd_write_out), 32'h0);
    checkOutput("late_rvalid_val", rd_value_out, 32'h0);
    @(negedge clk);
    checkOutput("late_rvalid_wr2", 32'(rd_write_out), 32'h0);
    checkOutput("late_rvalid_stall", 32'(stall_out), 32'h0);

    // An instruction held during a stall is taken only once back in IDLE.
    v = vecs[11];
    applyStimulus(v);
    valid_in = 1'b1; alu_opcode_in = OPI; result_in = 32'h55;
    rd_in = 5'd9; rd_write_in = 1'b1;
    checkOutput("hold_req_wr", 32'(rd_write_out), 32'h0);
    data_gnt_in = 1'b1;
    @(negedge clk);
    data_gnt_in = 1'b0;
    checkOutput("hold_done_wr", 32'(rd_write_out), 32'h0);
    @(negedge clk);
    checkOutput("hold_idle_wr", 32'(rd_write_out), 32'h0);
    checkOutput("hold_idle_stall", 32'(stall_out), 32'h0);
    @(negedge clk);
    checkOutput("hold_taken_wr", 32'(rd_write_out), 32'h1);
    checkOutput("hold_taken_rd", 32'(rd_out), 32'd9);
    checkOutput("hold_taken_val", rd_value_out, 32'h55);
    valid_in = 1'b0;
    @(negedge clk);
    checkOutput("novalid_wr", 32'(rd_write_out), 32'h0);

`ifdef LSU_TIMEOUT_EN
    // gnt never comes: four cycles of request, then a bus error pulse.
    v = vecs[3];
    applyStimulus(v);
    reqs = 0; errs = 0; err_at = -1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      reqs += int'(data_req_out);
      if (bus_err_out) begin
        errs++;
        err_at = i;
      end
    end
    checkOutput("to_req_cycles", 32'(reqs), 32'd4);
    checkOutput("to_err_count", 32'(errs), 32'd1);
    checkOutput("to_err_at", 32'(err_at), 32'd4);
    checkOutput("to_stall", 32'(stall_out), 32'h0);
    checkOutput("to_wr", 32'(rd_write_out), 32'h0);
    runVector(vecs[0]);
`else
    // Without the timeout the request simply stays up.
    v = vecs[11];
    applyStimulus(v);
    reqs = 0; errs = 0; err_at = -1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      reqs += int'(data_req_out);
      errs += int'(bus_err_out);
    end
    checkOutput("nto_req_cycles", 32'(reqs), 32'd20);
    checkOutput("nto_err_count", 32'(errs), 32'd0);
    data_gnt_in = 1'b1;
    @(negedge clk);
    data_gnt_in = 1'b0;
    checkOutput("nto_done_req", 32'(data_req_out), 32'h0);
    @(negedge clk);
    checkOutput("nto_stall", 32'(stall_out), 32'h0);
    runVector(vecs[0]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
